// File: rtl/bus_mem_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_target_pkg
// Brief    : Shared memory-bus definitions: control field layout, bus width
//            defaults, target FSM encoding and the error read-back word.
// Revision : 1.0 - initial release
// ============================================================================
package bus_mem_target_pkg;

    localparam int BUS_ADDR_W     = 14;
    localparam int BUS_DATA_W     = 32;

    localparam int CTRL_WRITE_BIT = 0;
    localparam int CTRL_BE_LSB    = 1;
    localparam int CTRL_BE_W      = 4;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    typedef struct packed {
        logic                 write;
        logic [CTRL_BE_W-1:0] be;
    } req_ctrl_t;

    function automatic req_ctrl_t decode_ctrl(input logic [7:0] ctrl);
        req_ctrl_t d;
        d.write = ctrl[CTRL_WRITE_BIT];
        d.be    = ctrl[CTRL_BE_LSB +: CTRL_BE_W];
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_array
// Brief    : Single-port synchronous RAM, per-byte write enables, registered
//            read port (read register clears on reset, contents do not).
// Revision : 1.0 - initial release
// ============================================================================
module bus_mem_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int c_lanes = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int l = 0; l < c_lanes; l++) begin
                if (i_be[l]) begin
                    r_mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_mem_target.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_target
// Brief    : Memory responder on the shared bus (arbiter target slot 0) with
//            a four-phase req/fulfilled handshake and configurable wait states.
//            Optional macro BUS_TGT_RANGE_CHECK_EN: out-of-range accesses are
//            flagged on tgt_error instead of aliasing.
// Revision : 1.0 - initial release
// ============================================================================
module bus_mem_target
    import bus_mem_target_pkg::*;
#(
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int DATA_W      = BUS_DATA_W,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tgt_req,
    input  logic [ADDR_W-1:0] tgt_address,
    input  logic [DATA_W-1:0] tgt_wdata,
    input  logic [7:0]        tgt_control,
    output logic [DATA_W-1:0] tgt_rdata,
    output logic              tgt_available,
    output logic              tgt_fulfilled,
    output logic              tgt_error
);

    localparam int         c_ram_aw    = $clog2(DEPTH);
    localparam logic [3:0] c_wait_init = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [2:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    req_ctrl_t         r_ctrl;

    logic              w_oor;
    logic              w_access;
    logic              w_we;
    logic              w_re;
    logic [DATA_W-1:0] w_arr_rdata;
    logic              w_unused_ctrl;

    assign w_unused_ctrl = ^tgt_control[7:5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ctrl     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tgt_req) begin
                        r_addr  <= tgt_address;
                        r_wdata <= tgt_wdata;
                        r_ctrl  <= decode_ctrl(tgt_control);
                        if (WAIT_CYCLES > 0) begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= c_wait_init;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: r_state <= ST_RESP;
                ST_RESP:   r_state <= ST_HOLD;
                // A request dropped early falls straight through here.
                ST_HOLD: begin
                    if (!tgt_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign tgt_available = (r_state == ST_IDLE);
    assign tgt_fulfilled = (r_state == ST_RESP);
    assign w_access      = (r_state == ST_ACCESS);
    assign w_oor         = |(r_addr >> c_ram_aw);
    assign w_re          = w_access && !r_ctrl.write;

`ifdef BUS_TGT_RANGE_CHECK_EN
    logic r_rd_err;

    assign w_we = w_access && r_ctrl.write && !w_oor;

    // Remembers whether the last read was out of range; writes leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_err <= 1'b0;
        end else if (w_re) begin
            r_rd_err <= w_oor;
        end
    end

    assign tgt_rdata = r_rd_err ? DATA_W'(ERR_RDATA) : w_arr_rdata;
    assign tgt_error = (r_state == ST_RESP) && w_oor;
`else
    logic w_unused_addr_hi;

    assign w_we             = w_access && r_ctrl.write;
    assign w_unused_addr_hi = w_oor;
    assign tgt_rdata        = w_arr_rdata;
    assign tgt_error        = 1'b0;
`endif

    bus_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (c_ram_aw)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_be    (r_ctrl.be),
        .i_addr  (r_addr[c_ram_aw-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_mem_target
// Brief    : Scoreboard bench for bus_mem_target: handshake, latency, byte
//            lanes, reset abort and address wrap / range check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_mem_target;
    import bus_mem_target_pkg::*;

    localparam int ADDR_W      = 14;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 1024;
    localparam int WAIT_CYCLES = 1;
`ifdef BUS_TGT_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tgt_req = 1'b0;
    logic [ADDR_W-1:0] tgt_address = '0;
    logic [DATA_W-1:0] tgt_wdata = '0;
    logic [7:0]        tgt_control = '0;
    logic [DATA_W-1:0] tgt_rdata;
    logic              tgt_available;
    logic              tgt_fulfilled;
    logic              tgt_error;

    bus_mem_target #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tgt_req       (tgt_req),
        .tgt_address   (tgt_address),
        .tgt_wdata     (tgt_wdata),
        .tgt_control   (tgt_control),
        .tgt_rdata     (tgt_rdata),
        .tgt_available (tgt_available),
        .tgt_fulfilled (tgt_fulfilled),
        .tgt_error     (tgt_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rdata = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic bit is_oor(input logic [ADDR_W-1:0] a);
        return RC && (int'(a) >= DEPTH);
    endfunction

    // Predicts, drives one transaction, then checks latency, data and release.
    task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] data, input logic [3:0] be,
                           input int hold_extra, input bit drop_early);
        exp_t e;
        exp_t g;
        int   idx;
        int   lat;
        int   k;
        bit   seen;
        idx   = int'(addr) % DEPTH;
        e.wr  = wr;
        e.err = is_oor(addr);
        if (wr) begin
            if (!e.err) begin
                for (int l = 0; l < 4; l++) begin
                    if (be[l]) model[idx][l*8 +: 8] = data[l*8 +: 8];
                end
            end
            e.rdata = last_rdata;
        end else begin
            e.rdata    = e.err ? 32'hDEAD_BEEF : model[idx];
            last_rdata = e.rdata;
        end
        sb.push_back(e);

        @(negedge clk);
        tgt_req     = 1'b1;
        tgt_address = addr;
        tgt_wdata   = data;
        tgt_control = {3'b101, be, wr};
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (tgt_fulfilled) seen = 1'b1;
            if (lat == 1) begin
                tgt_address = ~addr;
                tgt_wdata   = ~data;
                tgt_control = ~tgt_control;
                if (drop_early) tgt_req = 1'b0;
            end
        end
        n_checks++;
        if (!seen || lat != WAIT_CYCLES + 2) begin
            n_fail++;
            $display("FAIL latency addr=%h: got %0d cycles (seen=%0b), want %0d", addr, lat, seen, WAIT_CYCLES + 2);
        end
        if (seen) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: fulfilled with no expected entry");
            end else begin
                g = sb.pop_front();
                if (tgt_rdata !== g.rdata || tgt_error !== g.err) begin
                    n_fail++;
                    $display("FAIL %s addr=%h: rdata=%h err=%b, want rdata=%h err=%b",
                             g.wr ? "write" : "read", addr, tgt_rdata, tgt_error, g.rdata, g.err);
                end
            end
        end
        for (int c = 0; c < hold_extra; c++) begin
            @(negedge clk);
            n_checks++;
            if (tgt_fulfilled !== 1'b0 || tgt_available !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle %0d: fulfilled=%b available=%b, want 0 0", c, tgt_fulfilled, tgt_available);
            end
        end
        tgt_req = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tgt_available && k < 8);
        n_checks++;
        if (!tgt_available || k != ((hold_extra > 0) ? 1 : 2)) begin
            n_fail++;
            $display("FAIL release: available after %0d cycles (avail=%b), want %0d", k, tgt_available, (hold_extra > 0) ? 1 : 2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tgt_available !== 1'b1 || tgt_fulfilled !== 1'b0 || tgt_rdata !== 32'h0 || tgt_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: avail=%b ful=%b rdata=%h err=%b, want 1 0 00000000 0",
                     tgt_available, tgt_fulfilled, tgt_rdata, tgt_error);
        end
        rst_n      = 1'b1;
        last_rdata = 32'h0;
    endtask

    task automatic test_write_read();
        run_txn(1'b1, 14'h005, 32'h1234_5678, 4'hF, 0, 1'b0);
        run_txn(1'b0, 14'h005, 32'h0, 4'h0, 0, 1'b0);
        n_checks++;
        if (tgt_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL write_read held rdata: got %h want 12345678", tgt_rdata);
        end
    endtask

    task automatic test_byte_lanes();
        run_txn(1'b1, 14'h005, 32'hAABB_CCDD, 4'b0101, 0, 1'b0);
        run_txn(1'b0, 14'h005, 32'h0, 4'hF, 0, 1'b0);
        n_checks++;
        if (tgt_rdata !== 32'h12BB_56DD) begin
            n_fail++;
            $display("FAIL byte_lanes: got %h want 12BB56DD", tgt_rdata);
        end
        run_txn(1'b1, 14'h005, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0);
        run_txn(1'b0, 14'h005, 32'h0, 4'h0, 0, 1'b0);
    endtask

    task automatic test_hold_req();
        run_txn(1'b1, 14'h020, 32'hCAFE_0020, 4'hF, 10, 1'b0);
        run_txn(1'b0, 14'h020, 32'h0, 4'hF, 3, 1'b0);
    endtask

    task automatic test_early_drop();
        run_txn(1'b0, 14'h005, 32'h0, 4'hF, 0, 1'b1);
        run_txn(1'b1, 14'h021, 32'h5A5A_A5A5, 4'hF, 0, 1'b1);
        run_txn(1'b0, 14'h021, 32'h0, 4'hF, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_txn(1'b1, 14'h010, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
        @(negedge clk);
        tgt_req     = 1'b1;
        tgt_address = 14'h010;
        tgt_wdata   = 32'hFFFF_FFFF;
        tgt_control = 8'b0001_1111;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tgt_available !== 1'b1 || tgt_fulfilled !== 1'b0 || tgt_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: avail=%b ful=%b rdata=%h, want 1 0 00000000", tgt_available, tgt_fulfilled, tgt_rdata);
        end
        tgt_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        last_rdata = 32'h0;
        run_txn(1'b0, 14'h010, 32'h0, 4'hF, 0, 1'b0);
        n_checks++;
        if (tgt_rdata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL reset_mid lost write: got %h want 0BADF00D", tgt_rdata);
        end
    endtask

    task automatic test_wrap();
        run_txn(1'b1, 14'(3), 32'h0000_5555, 4'hF, 0, 1'b0);
        run_txn(1'b1, 14'(DEPTH + 3), 32'h0000_1234, 4'hF, 0, 1'b0);
        run_txn(1'b0, 14'(3), 32'h0, 4'hF, 0, 1'b0);
        n_checks++;
`ifdef BUS_TGT_RANGE_CHECK_EN
        if (tgt_rdata !== 32'h0000_5555) begin
            n_fail++;
            $display("FAIL wrap suppressed: got %h want 00005555", tgt_rdata);
        end
`else
        if (tgt_rdata !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL wrap alias: got %h want 00001234", tgt_rdata);
        end
`endif
        run_txn(1'b0, 14'(DEPTH + 3), 32'h0, 4'hF, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            run_txn(1'b1, 14'(8'h40 + i), d, 4'hF, 0, 1'b0);
        end
        for (int i = 5; i >= 0; i--) begin
            run_txn(1'b0, 14'(8'h40 + i), 32'h0, 4'($urandom_range(0, 15)), 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_hold_req();
        test_early_drop();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bus_mem_target.md
Name: bus_mem_target

Overview:
- Responder end of the shared memory bus. It services the single-word read and write requests that bus initiators (e.g. the UART debugger) issue through the bus arbiter.
- Holds a word-addressed RAM array with a configurable number of wait states.
- Completes every transaction with a one-cycle fulfilled pulse under a four-phase request handshake.
- Sits behind the arbiter as target slot 0.

Parameters:
- ADDR_W, 14, bus word-address width.
- DATA_W, 32, bus data width; must be 32 (four byte lanes).
- DEPTH, 1024, number of RAM words; power of two, at most 2^ADDR_W.
- WAIT_CYCLES, 1, extra cycles inserted between request capture and array access; 0..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tgt_req  input  1  request from arbiter; held high until tgt_fulfilled is seen, then dropped.
- tgt_address  input  ADDR_W  word address; sampled on acceptance.
- tgt_wdata  input  DATA_W  write data; sampled on acceptance.
- tgt_control  input  8  bit0 = write(1)/read(0); bits[4:1] = byte enables for lanes 0..3; bits[7:5] reserved, ignored.
- tgt_rdata  output  DATA_W  read data; valid while tgt_fulfilled is high, then held.
- tgt_available  output  1  high only in IDLE; feeds the arbiter's availability vector.
- tgt_fulfilled  output  1  one-cycle completion pulse.
- tgt_error  output  1  error flag; valid with tgt_fulfilled (see Optional Feature).

Behaviour:
- Reset values:
  - state = IDLE, tgt_available = 1, tgt_fulfilled = 0, tgt_rdata = 0, tgt_error = 0, wait counter = 0.
  - RAM contents are not reset.
- States:
  - IDLE: on tgt_req = 1 at edge N, latch address, control and wdata; drop tgt_available.
    - WAIT_CYCLES > 0: go to WAIT, counter = WAIT_CYCLES-1.
    - WAIT_CYCLES = 0: go to ACCESS.
  - WAIT: decrement the counter each cycle; at 0 go to ACCESS. Exactly WAIT_CYCLES cycles are spent in WAIT.
  - ACCESS, one cycle:
    - Write: update only the lanes whose enable is set; byte enables 0000 is a legal no-op write.
    - Read: register array[addr] into tgt_rdata; byte enables are ignored (full word returned).
    - Next state: RESP.
  - RESP: tgt_fulfilled = 1 for exactly this cycle. A write leaves tgt_rdata unchanged. Next state: HOLD.
  - HOLD: wait for tgt_req = 0, then go to IDLE. tgt_available rises in the cycle after req is seen low.
- Latency:
  - Req accepted at edge N; fulfilled high in cycle N+2+WAIT_CYCLES.
  - Next request can be accepted no earlier than 2 cycles after req falls.
- Address handling: only the low log2(DEPTH) bits index the RAM; higher addresses alias (wrap-around) unless the optional feature is enabled.
- tgt_address, tgt_wdata and tgt_control changes after acceptance are ignored.
- Read-after-write to the same address returns the new data.
- A tgt_req that drops before fulfilled is not aborted: the transaction completes, then HOLD exits immediately.
- Reset asserted mid-transaction: immediate return to IDLE; outputs take their reset values.
  - A write whose ACCESS cycle has not occurred is lost; a completed write persists.

Optional Feature:
- Macro BUS_TGT_RANGE_CHECK_EN.
- Defined:
  - Addresses >= DEPTH are out of range: writes are suppressed and reads return 32'hDEAD_BEEF.
  - tgt_error = 1 during the RESP cycle of such a transaction and 0 otherwise.
  - Timing is unchanged.
- Undefined: aliasing as above; tgt_error is tied to 0.

Decomposition:
- Shared bus package holds:
  - Control bit positions: CTRL_WRITE_BIT = 0, CTRL_BE_LSB = 1, CTRL_BE_W = 4.
  - ADDR_W / DATA_W defaults.
  - Target state encoding: IDLE, WAIT, ACCESS, RESP, HOLD.
  - Error read-back constant.
- One sub-module, bus_mem_array: a single-port synchronous RAM with per-byte write enables and registered read. It keeps array inference separate from the handshake FSM.

Test Plan:
- Reset: rst_n low for 3 cycles -> tgt_available = 1, tgt_fulfilled = 0, tgt_rdata = 0.
- Write then read, WAIT_CYCLES = 1:
  - Write addr 0x005, data 0x12345678, byte enables 1111 -> fulfilled 3 cycles after acceptance.
  - Read addr 0x005 -> tgt_rdata = 0x12345678 with fulfilled.
- Byte-lane write: addr 0x005, data 0xAABBCCDD, byte enables 0101 -> readback 0x12BB56DD.
- Handshake:
  - Hold req high for 10 cycles after fulfilled -> only one fulfilled pulse; tgt_available stays 0 until req drops, rising one cycle after.
  - Drop req mid-WAIT -> fulfilled still pulses once.
- Reset mid-operation: assert rst_n low in WAIT of a write to 0x010 of 0xFFFFFFFF -> IDLE; later read of 0x010 returns the prior value.
- Address wrap: write 0x1234 to addr DEPTH+3.
  - Macro undefined: read addr 3 returns 0x1234.
  - BUS_TGT_RANGE_CHECK_EN defined: tgt_error = 1 on that write; addr 3 unchanged; a read of addr DEPTH+3 returns 0xDEADBEEF with error = 1.
